// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
// 32-step shift-add multiply and restoring divide on operand magnitudes, with a
// sign fixup at the end; divide-by-zero and signed overflow resolve at start.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies complete in one cycle
// using a 33x33 signed product; divides stay iterative.
module muldiv_seq (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        flush,
    output logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [XLEN-1:0]   acc, acc_d;      // product high word / partial remainder
    logic [XLEN-1:0]   mpl, mpl_d;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]   mcand, mcand_d;  // multiplicand / divisor magnitude
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   result_d;

    // start-edge operand decode
    logic              a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    // per-step datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;

    // fixup datapath
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, fix_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]          fast_res;
`endif

    // operand signedness, magnitudes and special-case detection from the decode inputs
    always_comb begin
        a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                   (op == OP_DIV) || (op == OP_REM);
        neg_a    = a_signed & opA[XLEN-1];
        neg_b    = b_signed & opB[XLEN-1];
        abs_a    = neg_a ? (~opA + XLEN'(1)) : opA;
        abs_b    = neg_b ? (~opB + XLEN'(1)) : opB;
        div_zero = op[2] && (opB == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
        special  = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU within the divide group
        if (op[1]) begin
            special_res = div_zero ? opA : '0;
        end else begin
            special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // single-cycle signed product with per-operand sign extension
    always_comb begin
        fast_a   = {a_signed & opA[XLEN-1], opA};
        fast_b   = {b_signed & opB[XLEN-1], opB};
        fast_p   = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
        fast_res = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    // one iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc} + ({(XLEN+1){mpl[0]}} & {1'b0, mcand});
        div_shift = {acc, mpl[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift - {1'b0, mcand};
    end

    // sign correction and result selection at the end of the iterations
    always_comb begin
        prod   = {acc, mpl};
        prod_f = (neg_a_q ^ neg_b_q) ? (~prod + (2*XLEN)'(1)) : prod;
        quo_f  = (neg_a_q ^ neg_b_q) ? (~mpl + XLEN'(1)) : mpl;
        rem_f  = neg_a_q ? (~acc + XLEN'(1)) : acc;
        case (op_q)
            OP_MUL:               fix_res = prod_f[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     fix_res = prod_f[2*XLEN-1:XLEN];
            3'd4, 3'd5:           fix_res = quo_f;
            default:              fix_res = rem_f;
        endcase
    end

    // next-state and datapath update
    always_comb begin
        state_d  = state;
        count_d  = count;
        acc_d    = acc;
        mpl_d    = mpl;
        mcand_d  = mcand;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        op_d     = op_q;
        result_d = result;

        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                    acc_d   = '0;
                    mpl_d   = abs_a;
                    mcand_d = abs_b;
                    count_d = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!op[2]) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    acc_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    mpl_d = {mpl[XLEN-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    mpl_d = {mul_sum[0], mpl[XLEN-1:1]};
                end
                count_d = count + CNT_W'(1);
                if (count == CNT_W'(XLEN-1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // a kill aborts whatever is in flight and leaves the last result intact
        if (flush) begin
            state_d  = S_IDLE;
            count_d  = '0;
            result_d = result;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= S_IDLE;
            count   <= '0;
            acc     <= '0;
            mpl     <= '0;
            mcand   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            op_q    <= '0;
            result  <= '0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            acc     <= acc_d;
            mpl     <= mpl_d;
            mcand   <= mcand_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            op_q    <= op_d;
            result  <= result_d;
        end
    end

    // status decoded from the state register; hold also covers the accepting cycle
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE) && !flush;
        hold = ((state == S_IDLE) && start && !flush) ||
               (state == S_CALC) || (state == S_FIXUP);
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: iterative and special-case ops, flush and async reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    localparam int ITER_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = ITER_LAT;
`endif

    muldiv_seq dut (
        .clk    (clk),
        .rstN   (rstN),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .flush  (flush),
        .hold   (hold),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one op at a negedge, then track hold/busy until done or a cycle budget expires
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        logic stall_ok;
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        #1;
        check({tag, "_hold_c0"}, 32'(hold), 32'd1);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        stall_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (hold !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_stall"}, 32'(stall_ok), 32'd1);
        check({tag, "_hold_done"}, 32'(hold), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, result, exp);
    endtask

    initial begin
        int seen_done;
        rstN = 1'b0; start = 1'b0; op = 3'd0; opA = '0; opB = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hold", 32'(hold), 32'd0);
        rstN = 1'b1;

        // multiplies
        run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulhu_m1_m1",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulh_m1_m1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
        run_op("mulhsu_m1_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);

        // iterative divides
        run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, ITER_LAT);
        run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, ITER_LAT);
        run_op("divu_100_7", 3'd5, 32'd100,      32'd7, 32'd14,       ITER_LAT);
        run_op("remu_100_7", 3'd7, 32'd100,      32'd7, 32'd2,        ITER_LAT);

        // special cases resolved at the start edge
        run_op("divu_5_0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5_0",    3'd6, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // flush and start together: nothing accepted
        @(negedge clk);
        op = 3'd4; opA = 32'd9; opB = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check("fs_hold", 32'(hold), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("fs_busy", 32'(busy), 32'd0);
        check("fs_result", result, 32'h0);

        // flush a divide in flight at cycle 10
        @(negedge clk);
        op = 3'd4; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int i = 1; i < 10; i++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hold", 32'(hold), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done++;
            #1;
            if (done === 1'b1 && i == 0) seen_done++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        check("flush_result_kept", result, 32'h0);
        run_op("after_flush_divu", 3'd5, 32'd100, 32'd7, 32'd14, ITER_LAT);

        // async reset in the middle of a multiply
        @(negedge clk);
        op = 3'd0; opA = 32'd123; opB = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        #1;
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_hold", 32'(hold), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
